// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo -- synchronous first-in first-out buffer with a packed command port.
//
// Ports:
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-high reset (clears pointers, count, data_out)
//   vector_in    packed command: [WIDTH+2] wr, [WIDTH+1] rd, [WIDTH:1] din, [0] reserved
//   data_out     registered read data, updated on the edge that accepts a read
//   empty_flag   high when the FIFO holds no entries
//   full_flag    high when the FIFO holds DEPTH entries
//
// Writes while full and reads while empty are silently dropped. With both
// requests active, each one is accepted on its own merit, so a full FIFO
// performs only the read and an empty FIFO performs only the write.
// -----------------------------------------------------------------------------
module fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH+2:0] vector_in,
   output logic [WIDTH-1:0] data_out,
   output logic             empty_flag,
   output logic             full_flag
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Command fields
   logic             wr;
   logic             rd;
   logic [WIDTH-1:0] din;
   logic             unused_rsvd;

   assign wr          = vector_in[WIDTH+2];
   assign rd          = vector_in[WIDTH+1];
   assign din         = vector_in[WIDTH:1];
   assign unused_rsvd = vector_in[0];

   // State
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wp_q, wp_d;
   logic [AW-1:0]    rp_q, rp_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;

   logic wr_en;
   logic rd_en;

   // Flags come straight from the registered count, never from vector_in.
   assign empty_flag = (cnt_q == '0);
   assign full_flag  = (cnt_q == (AW+1)'(DEPTH));
   assign data_out   = dout_q;

   // Acceptance is judged against the current flags, so a full FIFO drops
   // the write even when a read frees a slot on the same edge.
   assign wr_en = wr & ~full_flag;
   assign rd_en = rd & ~empty_flag;

   // Explicit wrap keeps the pointers correct for non-power-of-two DEPTH.
   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   // NOTE: every always_comb output is assigned a default first so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;

      if (wr_en) begin
         wp_d = ptr_inc(wp_q);
      end
      if (rd_en) begin
         rp_d   = ptr_inc(rp_q);
         dout_d = mem[rp_q];
      end

      unique case ({wr_en, rd_en})
         2'b10:   cnt_d = cnt_q + (AW+1)'(1);
         2'b01:   cnt_d = cnt_q - (AW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples its next value from the same pre-edge snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   // NOTE: the storage array is deliberately not reset; cleared pointers and
   // count make stale entries unreachable, and leaving it out of reset lets it
   // map onto plain flops or RAM without a reset network.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp_q] <= din;
      end
   end

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo -- self-checking bench for fifo (DEPTH = 4, WIDTH = 4).
//
// A table of {command, expected data_out/empty/full} records is applied one
// clock per entry, followed by hand-written sequences for simultaneous
// read/write at each occupancy extreme and for a mid-operation reset.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge.
// -----------------------------------------------------------------------------
module tb_fifo;

   logic       clk;
   logic       reset;
   logic [6:0] vector_in;
   logic [3:0] data_out;
   logic       empty_flag;
   logic       full_flag;

   int n_checks;
   int n_fails;

   fifo #(.DEPTH(4), .WIDTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .vector_in  (vector_in),
      .data_out   (data_out),
      .empty_flag (empty_flag),
      .full_flag  (full_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [6:0] vin;
      logic [3:0] exp_dout;
      logic       exp_empty;
      logic       exp_full;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [6:0] cmd(input logic wr, input logic rd, input logic [3:0] d);
      return {wr, rd, d, 1'b0};
   endfunction

   function automatic vec_t mk(input string n, input logic [6:0] vin,
                               input logic [3:0] ed, input logic ee, input logic ef);
      vec_t v;
      v.name      = n;
      v.vin       = vin;
      v.exp_dout  = ed;
      v.exp_empty = ee;
      v.exp_full  = ef;
      return v;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string name, input logic [3:0] ed,
                             input logic ee, input logic ef);
      check({name, ".data_out"}, {4'h0, data_out}, {4'h0, ed});
      check({name, ".empty"},    {7'h0, empty_flag}, {7'h0, ee});
      check({name, ".full"},     {7'h0, full_flag},  {7'h0, ef});
   endtask

   // Drive a command for one clock and leave time positioned 1 ns after the edge.
   task automatic step(input logic [6:0] vin);
      @(negedge clk);
      vector_in = vin;
      @(posedge clk);
      #1;
   endtask

   task automatic step_check(input string name, input logic [6:0] vin,
                             input logic [3:0] ed, input logic ee, input logic ef);
      step(vin);
      check_outs(name, ed, ee, ef);
   endtask

   initial begin
      n_checks  = 0;
      n_fails   = 0;
      vector_in = '0;
      reset     = 1'b1;

      // Reset state visible asynchronously, before any clock edge
      #1;
      check_outs("reset_async", 4'h0, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Fill, overflow, drain, underflow, wrap-around, idle-with-garbage
      vecs.push_back(mk("idle0",   cmd(0, 0, 4'h0), 4'h0, 1, 0));
      vecs.push_back(mk("wrF",     cmd(1, 0, 4'hF), 4'h0, 0, 0));
      vecs.push_back(mk("wrE",     cmd(1, 0, 4'hE), 4'h0, 0, 0));
      vecs.push_back(mk("wrD",     cmd(1, 0, 4'hD), 4'h0, 0, 0));
      vecs.push_back(mk("wr9",     cmd(1, 0, 4'h9), 4'h0, 0, 1));
      vecs.push_back(mk("wr0_ovf", cmd(1, 0, 4'h0), 4'h0, 0, 1));
      vecs.push_back(mk("rd1",     cmd(0, 1, 4'h0), 4'hF, 0, 0));
      vecs.push_back(mk("rd2",     cmd(0, 1, 4'h0), 4'hE, 0, 0));
      vecs.push_back(mk("rd3",     cmd(0, 1, 4'h0), 4'hD, 0, 0));
      vecs.push_back(mk("rd4",     cmd(0, 1, 4'h0), 4'h9, 1, 0));
      vecs.push_back(mk("rd_unf",  cmd(0, 1, 4'h0), 4'h9, 1, 0));
      vecs.push_back(mk("w_wr0",   cmd(1, 0, 4'h0), 4'h9, 0, 0));
      vecs.push_back(mk("w_wr1",   cmd(1, 0, 4'h1), 4'h9, 0, 0));
      vecs.push_back(mk("w_wr7",   cmd(1, 0, 4'h7), 4'h9, 0, 0));
      vecs.push_back(mk("w_wr6",   cmd(1, 0, 4'h6), 4'h9, 0, 1));
      vecs.push_back(mk("w_rd0",   cmd(0, 1, 4'h0), 4'h0, 0, 0));
      vecs.push_back(mk("w_rd1",   cmd(0, 1, 4'h0), 4'h1, 0, 0));
      vecs.push_back(mk("w_rd7",   cmd(0, 1, 4'h0), 4'h7, 0, 0));
      vecs.push_back(mk("w_rd6",   cmd(0, 1, 4'h0), 4'h6, 1, 0));
      vecs.push_back(mk("idle_gb", 7'b00_1111_1,    4'h6, 1, 0));
      vecs.push_back(mk("rd_emp",  7'b01_1010_1,    4'h6, 1, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         step_check(vecs[i].name, vecs[i].vin, vecs[i].exp_dout,
                    vecs[i].exp_empty, vecs[i].exp_full);
      end

      // Simultaneous read/write with 2 entries: count stays at 2
      step_check("two_wrA",  cmd(1, 0, 4'hA), 4'h6, 0, 0);
      step_check("two_wrB",  cmd(1, 0, 4'hB), 4'h6, 0, 0);
      step_check("two_rw",   cmd(1, 1, 4'hC), 4'hA, 0, 0);
      step_check("two_rdB",  cmd(0, 1, 4'h0), 4'hB, 0, 0);
      step_check("two_rdC",  cmd(0, 1, 4'h0), 4'hC, 1, 0);

      // Simultaneous read/write when full: read done, write dropped
      step_check("full_w1",  cmd(1, 0, 4'h1), 4'hC, 0, 0);
      step_check("full_w2",  cmd(1, 0, 4'h2), 4'hC, 0, 0);
      step_check("full_w3",  cmd(1, 0, 4'h3), 4'hC, 0, 0);
      step_check("full_w4",  cmd(1, 0, 4'h4), 4'hC, 0, 1);
      step_check("full_rw",  cmd(1, 1, 4'h5), 4'h1, 0, 0);
      step_check("full_r2",  cmd(0, 1, 4'h0), 4'h2, 0, 0);
      step_check("full_r3",  cmd(0, 1, 4'h0), 4'h3, 0, 0);
      step_check("full_r4",  cmd(0, 1, 4'h0), 4'h4, 1, 0);
      step_check("full_r5",  cmd(0, 1, 4'h0), 4'h4, 1, 0);

      // Simultaneous read/write when empty: write done, data_out holds
      step_check("emp_rw",   cmd(1, 1, 4'h8), 4'h4, 0, 0);
      step_check("emp_rd8",  cmd(0, 1, 4'h0), 4'h8, 1, 0);

      // Mid-operation reset pulsed between edges
      step_check("mr_w1",    cmd(1, 0, 4'h1), 4'h8, 0, 0);
      step_check("mr_w2",    cmd(1, 0, 4'h2), 4'h8, 0, 0);
      step_check("mr_w3",    cmd(1, 0, 4'h3), 4'h8, 0, 0);
      @(negedge clk);
      vector_in = '0;
      reset     = 1'b1;
      #1;
      check_outs("mr_async", 4'h0, 1'b1, 1'b0);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check_outs("mr_hold",  4'h0, 1'b1, 1'b0);
      step_check("mr_rd",    cmd(0, 1, 4'h0), 4'h0, 1, 0);
      step_check("mr_w5",    cmd(1, 0, 4'h5), 4'h0, 0, 0);
      step_check("mr_rd5",   cmd(0, 1, 4'h0), 4'h5, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 The module SHALL have parameters DEPTH = 4 (number of entries) and WIDTH = 4 (data bits per entry); all values below assume these defaults.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port vector_in, input, 7 bits: packed command word.
- bit 6 = write request (wr)
- bit 5 = read request (rd)
- bits 4:1 = write data (din)
- bit 0 = reserved
REQ-005 Port data_out, output, 4 bits: registered read data.
REQ-006 Port empty_flag, output, 1 bit: high when the FIFO holds 0 entries.
REQ-007 Port full_flag, output, 1 bit: high when the FIFO holds DEPTH entries.

Function
REQ-008 Storage SHALL be a DEPTH x WIDTH register array with the following state:
- write pointer wp, log2(DEPTH) bits
- read pointer rp, log2(DEPTH) bits
- occupancy count cnt, log2(DEPTH)+1 bits, range 0..DEPTH
REQ-009 The FIFO SHALL be first-in first-out: entries are read in exactly the order they were accepted.
REQ-010 Write accepted when wr=1 and full_flag=0: on that edge, mem[wp] <= din and wp <= wp+1.
REQ-011 Read accepted when rd=1 and empty_flag=0: on that edge, data_out <= mem[rp] and rp <= rp+1.
- Read data is visible on data_out immediately after the accepting edge (1-cycle latency).
REQ-012 Pointers SHALL wrap modulo DEPTH (3 -> 0) with no gap and no data corruption.
REQ-013 A write while full SHALL be ignored: memory, pointers, cnt and data_out are unchanged, and no error signal is raised.
REQ-014 A read while empty SHALL be ignored: data_out holds its previous value and the pointers are unchanged.
REQ-015 Simultaneous wr=1 and rd=1:
- not empty and not full: both operations are performed and cnt is unchanged.
- full: the read is performed and the write is ignored, so cnt decreases by 1.
- empty: the write is performed and the read is ignored, so cnt increases by 1 and data_out holds.
REQ-016 cnt update: +1 on a write-only accept, -1 on a read-only accept, unchanged otherwise.
REQ-017 Flag derivation: empty_flag = (cnt == 0) and full_flag = (cnt == DEPTH).
- Both flags SHALL be decoded from registered state only, with no combinational path from vector_in.
- Both flags reflect an accepted operation immediately after its edge.
REQ-018 When wr=0 and rd=0, all state SHALL be held; bits 4:1 and bit 0 are then don't-care.
REQ-019 vector_in SHALL be sampled only at the rising edge of clk; changes between edges have no effect.

Reset
REQ-020 While reset=1, asynchronously and independently of clk:
- wp, rp and cnt SHALL be 0
- data_out SHALL be 4'h0
- empty_flag SHALL be 1 and full_flag SHALL be 0
REQ-021 Memory contents need not be cleared; after reset they are unreachable.
REQ-022 Asserting reset mid-operation SHALL discard all stored entries, and the first edge after deassertion SHALL behave as on an empty FIFO.

Verification
REQ-023 Reset then idle: assert reset, then release with vector_in = 0 -> empty_flag=1, full_flag=0, data_out=0.
REQ-024 Fill and overflow:
- 4 consecutive writes of F, E, D, 9 (vector_in = 7'b10_dddd_0) -> full_flag=1 after the 4th edge, and empty_flag=0 after the 1st edge.
- 5th write of 0 -> ignored, full_flag stays 1.
REQ-025 Drain and underflow:
- 4 reads (7'b01_0000_0) -> data_out = F, E, D, 9 on successive edges, and empty_flag=1 after the 4th.
- 5th read -> data_out stays 9.
REQ-026 Wrap-around: after the drain above, write 0, 1, 7, 6, then read 4 -> data_out = 0, 1, 7, 6 and full/empty sequence correct.
REQ-027 Simultaneous read and write, each with wr=rd=1:
- with 2 entries -> cnt stays 2 and the read returns the oldest entry.
- with a full FIFO -> full_flag drops and the written value is not stored.
- with an empty FIFO -> empty_flag drops and data_out holds.
REQ-028 Mid-operation reset: write 3 entries, pulse reset between edges -> immediate empty_flag=1, data_out=0; a following read returns nothing and data_out stays 0.
